// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and its stall-decode users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_PREP = 2'd1,
    MD_CALC = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  // Even encodings (MULT, DIV) are the signed flavours.
  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negate of a W-bit value.
// Latency: combinational.
// Backpressure: none.
module cond_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU producing the HI/LO pair, plus MTHI/MTLO write port.
// Latency: 34 cycles from accepted start to done (1 PREP + ITER CALC + 1 FIX).
// Backpressure: busy high while not IDLE; start and HI/LO writes are ignored while busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER);

  md_state_e    r_state;
  md_state_e    w_next;
  md_op_e       r_op;
  logic [31:0]  r_a;
  logic [31:0]  r_b;
  logic [31:0]  r_ma;
  logic [31:0]  r_mb;
  logic [63:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic         r_neg_lo;
  logic         r_neg_hi;
  logic [31:0]  r_hi;
  logic [31:0]  r_lo;
  logic         r_done;
  logic         r_dz;

  logic         w_sgn;
  logic         w_div;
  logic         w_last;
  logic         w_fix;
  logic [31:0]  w_n0_in;
  logic [31:0]  w_n1_in;
  logic         w_n0_neg;
  logic         w_n1_neg;
  logic [31:0]  w_n0_out;
  logic [31:0]  w_n1_out;
  logic [63:0]  w_prod;
  logic [32:0]  w_msum;
  logic [32:0]  w_shift;
  logic [33:0]  w_diff;
  logic         w_fits;
  logic [31:0]  w_rem;

  assign w_sgn  = md_is_signed(r_op);
  assign w_div  = md_is_div(r_op);
  assign w_last = (r_cnt == CW'(ITER - 1));
  assign w_fix  = (r_state == MD_FIX);

  // The two 32-bit negators are shared: operand abs in PREP, quotient/remainder fix-up in FIX.
  assign w_n0_in  = w_fix ? r_acc[31:0]  : r_a;
  assign w_n0_neg = w_fix ? r_neg_lo     : (w_sgn & r_a[31]);
  assign w_n1_in  = w_fix ? r_acc[63:32] : r_b;
  assign w_n1_neg = w_fix ? r_neg_hi     : (w_sgn & r_b[31]);

  cond_negate #(.W(32)) u_neg_lo (.i_neg(w_n0_neg), .i_val(w_n0_in), .o_val(w_n0_out));
  cond_negate #(.W(32)) u_neg_hi (.i_neg(w_n1_neg), .i_val(w_n1_in), .o_val(w_n1_out));
  cond_negate #(.W(64)) u_neg_pr (.i_neg(r_neg_lo), .i_val(r_acc),   .o_val(w_prod));

  // Multiply step: add multiplicand into the upper half when the current multiplier bit is set.
  assign w_msum = {1'b0, r_acc[63:32]} + {1'b0, r_ma};

  // Restoring-divide step: 33-bit partial remainder is the old remainder with the next dividend bit.
  assign w_shift = {r_acc[63:32], r_ma[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_mb};
  assign w_fits  = ~w_diff[33];
  assign w_rem   = w_fits ? w_diff[31:0] : w_shift[31:0];

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (start) w_next = MD_PREP;
      MD_PREP: w_next = MD_CALC;
      MD_CALC: if (w_last) w_next = MD_FIX;
      MD_FIX:  w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
  end

  // Operand capture, iteration datapath, HI/LO update and completion pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op     <= MD_MULT;
      r_a      <= '0;
      r_b      <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_op <= md_op_e'(op);
            r_a  <= a;
            r_b  <= b;
          end else begin
            if (wr_hi) r_hi <= wr_data;
            if (wr_lo) r_lo <= wr_data;
          end
        end
        MD_PREP: begin
          r_ma     <= w_n0_out;
          r_mb     <= w_n1_out;
          r_neg_lo <= w_sgn & (r_a[31] ^ r_b[31]);
          r_neg_hi <= w_sgn & r_a[31];
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        MD_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_div) begin
            r_acc <= {w_rem, r_acc[30:0], w_fits};
            r_ma  <= {r_ma[30:0], 1'b0};
          end else begin
            if (r_mb[0]) r_acc <= {w_msum, r_acc[31:1]};
            else         r_acc <= {1'b0, r_acc[63:1]};
            r_mb <= {1'b0, r_mb[31:1]};
          end
        end
        MD_FIX: begin
          r_done <= 1'b1;
          if (w_div && (r_b == 32'd0)) begin
            r_hi <= r_a;
            r_lo <= 32'hFFFF_FFFF;
            r_dz <= 1'b1;
          end else if (w_div) begin
            r_hi <= w_n1_out;
            r_lo <= w_n0_out;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != MD_IDLE);
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
// Latency: expects done exactly 34 edges after the start edge.
// Backpressure: exercises start/writes while busy and start+write collisions.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected architectural HI/LO.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clock = ~clock;

  muldiv_unit #(.ITER(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic [63:0]     q;
    logic [63:0]     r;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    ua  = {32'd0, ma};
    ub  = {32'd0, mb};
    edz = 1'b0;
    p   = 64'd0;
    q   = 64'd0;
    r   = 64'd0;
    case (mop)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: if (mb != 0) begin q = sa / sb; r = sa % sb; end
      default: if (mb != 0) begin q = ua / ub; r = ua % ub; end
    endcase
    if (mop[1] == 1'b0) begin
      eh = p[63:32];
      el = p[31:0];
    end else if (mb == 32'd0) begin
      eh  = ma;
      el  = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else begin
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  // Launch one op and watch a bounded 40-cycle window after the start edge.
  // inj_start / inj_wr: cycle index at which to poke start or HI/LO writes while busy (-1 = never).
  task automatic run_op(input string nm, input logic [1:0] t_op, input logic [31:0] t_a,
                        input logic [31:0] t_b, input int inj_start, input int inj_wr, input bit wl);
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    logic [31:0] gh;
    logic [31:0] gl;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          done_at;
    int          busy_n;
    int          done_n;
    int          dz_n;
    model(t_op, t_a, t_b, eh, el, edz);
    pre_hi  = m_hi;
    pre_lo  = m_lo;
    done_at = -1;
    busy_n  = 0;
    done_n  = 0;
    dz_n    = 0;
    gh      = 32'd0;
    gl      = 32'd0;
    @(negedge clock);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    if (wl) begin
      wr_lo   = 1'b1;
      wr_data = 32'hDEAD_BEEF;
    end
    @(negedge clock);
    start = 1'b0;
    wr_lo = 1'b0;
    if (wl) chk({nm, "_lo_wr_with_start"}, 64'(lo), 64'(pre_lo));
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_n++;
      if (div_zero) dz_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = k;
          gh = hi;
          gl = lo;
        end
      end
      if (inj_wr >= 0 && k == inj_wr + 1) begin
        chk({nm, "_busy_wr_hi"}, 64'(hi), 64'(pre_hi));
        chk({nm, "_busy_wr_lo"}, 64'(lo), 64'(pre_lo));
      end
      if (k == inj_start) begin
        start = 1'b1;
        op    = ~t_op;
        a     = $urandom;
        b     = $urandom;
      end
      if (k == inj_wr) begin
        wr_hi   = 1'b1;
        wr_lo   = 1'b1;
        wr_data = 32'h1357_9BDF;
      end
      @(negedge clock);
      start = 1'b0;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
    end
    chk({nm, "_done_cycle"}, 64'(done_at), 64'(34));
    chk({nm, "_done_count"}, 64'(done_n), 64'(1));
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(34));
    chk({nm, "_div_zero"}, 64'(dz_n), 64'(edz));
    chk({nm, "_hi"}, 64'(gh), 64'(eh));
    chk({nm, "_lo"}, 64'(gl), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic wr_reg(input bit sel_hi, input bit sel_lo, input logic [31:0] d);
    @(negedge clock);
    wr_hi   = sel_hi;
    wr_lo   = sel_lo;
    wr_data = d;
    @(negedge clock);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    if (sel_hi) m_hi = d;
    if (sel_lo) m_lo = d;
    chk("mt_hi", 64'(hi), 64'(m_hi));
    chk("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int rst_done;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    a       = 32'd0;
    b       = 32'd0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    wr_data = 32'd0;
    repeat (3) @(negedge clock);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    reset = 1'b0;

    run_op("mult_neg",   2'b00, 32'hFFFF_FFFD, 32'd5,          -1, -1, 1'b0);
    run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  -1, -1, 1'b0);
    run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'd2,          -1, -1, 1'b0);
    run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  -1, -1, 1'b0);
    run_op("divu_zero",  2'b11, 32'h0000_1234, 32'd0,          10, -1, 1'b0);
    run_op("div_zero_s", 2'b10, 32'h8765_4321, 32'd0,          -1, -1, 1'b0);

    wr_reg(1'b1, 1'b0, 32'hAAAA_0000);
    wr_reg(1'b0, 1'b1, 32'h0000_5555);
    run_op("busy_wr",    2'b01, 32'd1000,      32'd77,          -1, 5, 1'b0);
    wr_reg(1'b1, 1'b1, 32'h0F0F_F0F0);
    run_op("start_wl",   2'b11, 32'd1000,      32'd7,           -1, -1, 1'b1);

    // Abort a MULT partway through with reset.
    @(negedge clock);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'h1234_5678;
    b     = 32'h9ABC_DEF0;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    rst_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) rst_done++;
      @(negedge clock);
    end
    chk("abort_no_done", 64'(rst_done), 64'(0));
    run_op("multu_3x4",  2'b01, 32'd3,         32'd4,           -1, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op("rnd", 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
